keccak_rho_pi_walker: RTL and testbench

Parametrised lane-permutation engine for the sponge datapath. It holds a 5x5 state of W-bit lanes in an internal register file. On `start`, it walks the 24-position (x,y) -> (y, 2x+3y mod 5) cycle, applying rho (lane rotation), pi (lane relocation), or both in place, and writes one lane per cycle. It succeeds the fixed 5-bit, single-mode index walker: lane width is generalised, modes are selectable, and a host load/read port plus a start/busy/done handshake are added.

---
 rtl/keccak_rho_pi_walker_pkg.sv | 37 +++
 rtl/keccak_rho_pi_walker_lane_rotator.sv | 19 +
 rtl/keccak_rho_pi_walker.sv | 142 ++++++++++++++
 tb/tb_keccak_rho_pi_walker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_rho_pi_walker_pkg.sv
// Shared constants, enums and index helpers for the rho/pi lane walker.
package keccak_pkg;

  localparam int unsigned LANES   = 25;
  localparam int unsigned STEPS   = 24;
  localparam logic [2:0]  START_X = 3'd1;
  localparam logic [2:0]  START_Y = 3'd0;

  typedef enum logic [1:0] {
    MODE_RHOPI = 2'b00,
    MODE_RHO   = 2'b01,
    MODE_PI    = 2'b10,
    MODE_BYP   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WALK = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Flat lane index x + 5*y, built from shifts and adds.
  function automatic logic [4:0] lane_idx(input logic [2:0] x, input logic [2:0] y);
    return 5'(x) + {y, 2'b00} + 5'(y);
  endfunction

  // Reduce a value in 0..20 to 0..4 with at most four conditional subtractions.
  function automatic logic [2:0] mod5(input logic [4:0] v);
    logic [4:0] r;
    r = v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r >= 5'd5) r = r - 5'd5;
    end
    return r[2:0];
  endfunction

endpackage

// File: rtl/keccak_rho_pi_walker_lane_rotator.sv
// Combinational left rotation of one lane by a runtime offset.
module lane_rotator #(
  parameter int W    = 64,
  parameter int OFFW = 6
) (
  input  logic [W-1:0]    lane_i,
  input  logic [OFFW-1:0] off_i,
  output logic [W-1:0]    lane_o
);

  logic [2*W-1:0] dbl;

  // Shift a doubled copy so the bits leaving the top wrap into the upper half.
  always_comb begin
    dbl    = {lane_i, lane_i} << off_i;
    lane_o = (W == 1) ? lane_i : dbl[2*W-1:W];
  end

endmodule

// File: rtl/keccak_rho_pi_walker.sv
// In-place rho/pi lane permutation over a 5x5 register file of W-bit lanes.
module keccak_rho_pi_walker
  import keccak_pkg::*;
#(
  parameter int W    = 64,
  parameter int OFFW = (W > 1) ? $clog2(W) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [4:0]   rd_addr,
  output logic [W-1:0] rd_data,
  output logic         busy,
  output logic         done,
  output logic [4:0]   step
);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [4:0]      t_q, t_d;
  logic [2:0]      x_q, x_d, y_q, y_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [W-1:0]    cur_q, cur_d;
  logic [W-1:0]    lane_q [LANES];
  logic [W-1:0]    lane_d [LANES];

  logic [4:0]      pos_idx, n_idx, start_idx, waddr;
  logic [2:0]      nx, ny;
  logic [W-1:0]    rot_src, rot_out, wdata;

  // Walk geometry: current index and successor (y, 2x+3y mod 5).
  always_comb begin
    start_idx = lane_idx(START_X, START_Y);
    pos_idx   = lane_idx(x_q, y_q);
    nx        = y_q;
    ny        = mod5(5'({x_q, 1'b0}) + 5'({y_q, 1'b0}) + 5'(y_q));
    n_idx     = lane_idx(nx, ny);
  end

  // Rho-only rotates the lane in place; the pi modes move the carried lane forward.
  always_comb begin
    rot_src = (mode_q == MODE_RHO) ? lane_q[pos_idx] : cur_q;
    wdata   = (mode_q == MODE_PI)  ? cur_q : rot_out;
    waddr   = (mode_q == MODE_RHO) ? pos_idx : n_idx;
  end

  lane_rotator #(
    .W    (W),
    .OFFW (OFFW)
  ) u_rot (
    .lane_i (rot_src),
    .off_i  (off_q),
    .lane_o (rot_out)
  );

  // Next-state logic for the FSM, walk registers and lane file.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    t_d     = t_q;
    x_d     = x_q;
    y_d     = y_q;
    off_d   = off_q;
    cur_d   = cur_q;
    lane_d  = lane_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_en && (wr_addr < 5'(LANES))) lane_d[wr_addr] = wr_data;
        if (start) begin
          mode_d = mode_e'(mode);
          if (mode_e'(mode) == MODE_BYP) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WALK;
            t_d     = '0;
            x_d     = START_X;
            y_d     = START_Y;
            off_d   = OFFW'(1 % W);
            // A host write landing on the start lane in this same cycle must be seen by the walk.
            cur_d   = (wr_en && (wr_addr == start_idx)) ? wr_data : lane_q[start_idx];
          end
        end
      end
      S_WALK: begin
        lane_d[waddr] = wdata;
        if (mode_q != MODE_RHO) cur_d = lane_q[n_idx];
        x_d   = nx;
        y_d   = ny;
        off_d = OFFW'((32'(off_q) + 32'(t_q) + 32'd2) % 32'(W));
        if (t_q == 5'(STEPS - 1)) begin
          state_d = S_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 5'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous clear of the whole lane file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_RHOPI;
      t_q     <= '0;
      x_q     <= START_X;
      y_q     <= START_Y;
      off_q   <= '0;
      cur_q   <= '0;
      for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      t_q     <= t_d;
      x_q     <= x_d;
      y_q     <= y_d;
      off_q   <= off_d;
      cur_q   <= cur_d;
      lane_q  <= lane_d;
    end
  end

  // Host read port and status outputs.
  always_comb begin
    rd_data = '0;
    if (rd_addr < 5'(LANES)) rd_data = lane_q[rd_addr];
    busy = (state_q == S_WALK);
    done = (state_q == S_DONE);
    step = (state_q == S_WALK) ? t_q : 5'd0;
  end

endmodule

// File: tb/tb_keccak_rho_pi_walker.sv
// Directed self-checking bench for keccak_rho_pi_walker (W=64 and W=8 instances).
module tb_keccak_rho_pi_walker;

  logic        clk;
  logic        rst;

  logic        start, wr_en;
  logic [1:0]  mode;
  logic [4:0]  wr_addr, rd_addr, step;
  logic [63:0] wr_data, rd_data;
  logic        busy, done;

  logic        s8_start, s8_wr_en;
  logic [1:0]  s8_mode;
  logic [4:0]  s8_wr_addr, s8_rd_addr, s8_step;
  logic [7:0]  s8_wr_data, s8_rd_data;
  logic        s8_busy, s8_done;

  int checks   = 0;
  int failures = 0;

  keccak_rho_pi_walker #(.W(64)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .step(step)
  );

  keccak_rho_pi_walker #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .mode(s8_mode),
    .wr_en(s8_wr_en), .wr_addr(s8_wr_addr), .wr_data(s8_wr_data),
    .rd_addr(s8_rd_addr), .rd_data(s8_rd_data),
    .busy(s8_busy), .done(s8_done), .step(s8_step)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_lane(input string tag, input int a, input logic [63:0] exp);
    logic [63:0] v;
    rd_addr = 5'(a);
    #1;
    v = rd_data;
    check_eq(tag, v, exp);
  endtask

  task automatic load_identity();
    @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(i);
      wr_data = 64'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  // Launch a walk, follow it to done, and check handshake timing on the way.
  task automatic run_walk(input logic [1:0] m, input bit inject, input bit fwd,
                          input logic [63:0] fwd_data, input int exp_lat);
    int lat;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    if (fwd) begin
      wr_en   = 1'b1;
      wr_addr = 5'd1;
      wr_data = fwd_data;
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    lat   = 1;
    check_eq("busy_first", 64'(busy), 64'(exp_lat != 1));
    check_eq("step_first", 64'(step), 64'd0);
    while (!done && lat < 40) begin
      if (lat == 11) check_eq("step_mid", 64'(step), 64'd10);
      if (inject) begin
        if (step == 5'd5) begin
          start = 1'b1; mode = 2'b11; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEAD;
        end else if (step == 5'd7) begin
          start = 1'b0; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'hBEEF;
        end else begin
          start = 1'b0; wr_en = 1'b0;
        end
      end
      @(negedge clk);
      lat++;
    end
    wr_en = 1'b0;
    check_eq("done_latency", 64'(lat), 64'(exp_lat));
    check_eq("busy_at_done", 64'(busy), 64'd0);
    if (inject) begin
      start = 1'b1;
      mode  = 2'b00;
    end
    @(negedge clk);
    start = 1'b0;
    check_eq("done_pulse", 64'(done), 64'd0);
    if (inject) begin
      @(negedge clk);
      check_eq("start_in_done_ignored", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int lat8;
    int n;
    rst = 1'b0;
    start = 1'b0; mode = 2'b00; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    s8_start = 1'b0; s8_mode = 2'b00; s8_wr_en = 1'b0; s8_wr_addr = '0; s8_wr_data = '0; s8_rd_addr = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_step", 64'(step), 64'd0);
    check_lane("rst_lane5", 5, 64'd0);
    rst = 1'b1;

    // rho+pi on identity lanes
    load_identity();
    run_walk(2'b00, 1'b0, 1'b0, 64'd0, 25);
    check_lane("rhopi_lane10", 10, 64'h2);
    check_lane("rhopi_lane11", 11, 64'h1C0);
    check_lane("rhopi_lane6", 6, 64'h90_0000);
    check_lane("rhopi_lane1", 1, 64'h0000_6000_0000_0000);
    check_lane("rhopi_lane3", 3, 64'h240_0000);
    check_lane("rhopi_lane0", 0, 64'd0);
    check_lane("rd_oob", 25, 64'd0);

    // rho only
    load_identity();
    run_walk(2'b01, 1'b0, 1'b0, 64'd0, 25);
    check_lane("rho_lane1", 1, 64'h2);
    check_lane("rho_lane10", 10, 64'h50);
    check_lane("rho_lane7", 7, 64'h1C0);
    check_lane("rho_lane6", 6, 64'h0000_6000_0000_0000);
    check_lane("rho_lane0", 0, 64'd0);

    // pi only, with lane 1 rewritten in the start cycle
    load_identity();
    run_walk(2'b10, 1'b0, 1'b1, 64'h77, 25);
    check_lane("pi_fwd_lane10", 10, 64'h77);
    check_lane("pi_lane1", 1, 64'h6);
    check_lane("pi_lane6", 6, 64'h9);

    // W=8 rho only: offset at the last step is 300 mod 8 = 4
    @(negedge clk);
    s8_wr_en = 1'b1; s8_wr_addr = 5'd6; s8_wr_data = 8'h01;
    @(negedge clk);
    s8_wr_en = 1'b0; s8_start = 1'b1; s8_mode = 2'b01;
    @(negedge clk);
    s8_start = 1'b0;
    lat8 = 1;
    while (!s8_done && lat8 < 40) begin
      @(negedge clk);
      lat8++;
    end
    check_eq("w8_latency", 64'(lat8), 64'd25);
    s8_rd_addr = 5'd6;
    #1;
    check_eq("w8_lane6", 64'(s8_rd_data), 64'h10);
    s8_rd_addr = 5'd0;
    #1;
    check_eq("w8_lane0", 64'(s8_rd_data), 64'h0);

    // rho+pi with start/write/mode disturbances mid-walk
    load_identity();
    run_walk(2'b00, 1'b1, 1'b0, 64'd0, 25);
    check_lane("hs_lane3", 3, 64'h240_0000);
    check_lane("hs_lane0", 0, 64'd0);
    check_lane("hs_lane6", 6, 64'h90_0000);
    check_lane("hs_lane10", 10, 64'h2);

    // bypass leaves the state untouched
    run_walk(2'b11, 1'b0, 1'b0, 64'd0, 1);
    check_lane("byp_lane6", 6, 64'h90_0000);
    check_lane("byp_lane10", 10, 64'h2);

    // reset mid-walk
    @(negedge clk);
    start = 1'b1; mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (step != 5'd10 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_step10", 64'(step), 64'd10);
    rst = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    for (int i = 0; i < 25; i++) check_lane("midrst_lane", i, 64'd0);
    @(negedge clk);
    check_eq("midrst_no_done", 64'(done), 64'd0);
    rst = 1'b1;
    load_identity();
    run_walk(2'b01, 1'b0, 1'b0, 64'd0, 25);
    check_lane("post_rst_lane1", 1, 64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
